// File: rtl/alu_defs.sv
// Shared opcode, width and request-layout definitions for the ALU issue path.
package alu_defs;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REQ_W  = 2 * DATA_W + 2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_NOT = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        op;
  } alu_req_t;

  typedef enum logic {StEmpty, StFull} out_state_e;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO: storage, wrapping pointers, occupancy and upstream ready.
module alu_req_fifo
  import alu_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [REQ_W-1:0] wdata_i,
  output logic [REQ_W-1:0] head_o,
  output logic [PTR_W:0]   level_o,
  output logic             in_ready_o
);

  localparam logic [PTR_W:0] FullLevel = (PTR_W + 1)'(DEPTH);

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             push, pop;

  // Ready comes from registered level only, so a full FIFO stays not-ready during a pop.
  assign in_ready_o = (level_q != FullLevel);
  assign push       = push_i & in_ready_o;
  assign pop        = pop_i & (level_q != '0);
  assign level_o    = level_q;
  assign head_o     = (level_q != '0) ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu32_issue_queue.sv
// Issue queue feeding a combinational 32-bit ALU; head drives the ALU, result is registered.
module alu32_issue_queue
  import alu_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry,
  output logic              out_err,
  output logic [PTR_W:0]    level
);

  alu_req_t          wreq, head;
  logic [REQ_W-1:0]  head_bits;
  logic              load;
  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;
  logic              err_q, err_d;

  assign wreq = '{a: in_a, b: in_b, op: in_op};

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (in_valid),
    .pop_i      (load),
    .wdata_i    (wreq),
    .head_o     (head_bits),
    .level_o    (level),
    .in_ready_o (in_ready)
  );

  assign head   = alu_req_t'(head_bits);
  assign alu_a  = head.a;
  assign alu_b  = head.b;
  assign alu_op = head.op;

  assign out_valid  = (state_q == StFull);
  assign load       = (level != '0) & (~out_valid | out_ready);
  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_err    = err_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;
    unique case (state_q)
      StEmpty: if (load) state_d = StFull;
      StFull:  if (out_ready) state_d = load ? StFull : StEmpty;
      default: state_d = StEmpty;
    endcase
    if (load) begin
      // Reserved op never exposes the ALU output.
      result_d = (head.op == OP_RSV) ? '0 : alu_result;
      carry_d  = (head.op == OP_ADD) ? alu_carry : 1'b0;
      err_d    = (head.op == OP_RSV);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu32_issue_queue.sv
// Scoreboard bench for alu32_issue_queue with a behavioural ALU stub on the alu_* port.
module tb_alu32_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        alu_carry;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_carry, out_err;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  int cyc    = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;

  alu32_issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_err    (out_err),
    .level      (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ALU stub: non-add ops and op 3 report carry=1 and junk so masking is exercised.
  always_comb begin
    alu_carry  = 1'b1;
    alu_result = 32'hBAD0BAD0;
    case (alu_op)
      2'd0:    {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1:    alu_result = alu_a & alu_b;
      2'd2:    alu_result = ~alu_a;
      default: ;
    endcase
  end

  // Expected {err, carry, result} as seen on out_*.
  function automatic logic [33:0] model(input logic [31:0] a, b, input logic [1:0] op);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      2'd0:    return {1'b0, s};
      2'd1:    return {2'b00, a & b};
      2'd2:    return {2'b00, ~a};
      default: return {1'b1, 1'b0, 32'h0};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h", {out_err, out_carry, out_result});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_err, out_carry, out_result} !== mon_exp) begin
          errors++;
          $display("FAIL result got=%h exp=%h", {out_err, out_carry, out_result}, mon_exp);
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, op));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL push_timeout got=in_ready_low exp=accept");
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && level == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({level, in_ready, out_valid, out_result, out_carry, out_err} !== {3'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {level, in_ready, out_valid, out_result, out_carry, out_err},
               {3'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== 66'h0) begin
      errors++;
      $display("FAIL reset_alu_drive got=%h exp=0", {alu_a, alu_b, alu_op});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add_carry;
    bit ok;
    push(32'hFFFFFFFF, 32'h00000001, 2'd0);
    @(negedge clk);
    checks++;
    if ({out_valid, level} !== {1'b0, 3'd1}) begin
      errors++;
      $display("FAIL add_latency1 got=%b exp=%b", {out_valid, level}, {1'b0, 3'd1});
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_result, out_carry, out_err} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_latency2 got=%h exp=%h", {out_valid, out_result, out_carry, out_err}, {1'b1, 32'h0, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_drain got=busy exp=idle"); end
  endtask

  task automatic test_and_not;
    bit ok;
    push(32'hF0F0F0F0, 32'hFF00FF00, 2'd1);
    push(32'h0000FFFF, 32'h12345678, 2'd2);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL and_not_drain got=busy exp=idle"); end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [33:0] first;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h1000 * i + 7, i, 2'(i % 3));
    first = exp_q[0];
    in_valid = 1'b1; in_a = 32'h55; in_b = 32'h66; in_op = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, level, out_valid, out_err, out_carry, out_result} !== {1'b0, 3'd4, 1'b1, first}) begin
        errors++;
        $display("FAIL bp_stall got=%h exp=%h", {in_ready, level, out_valid, out_err, out_carry, out_result},
                 {1'b0, 3'd4, 1'b1, first});
      end
      checks++;
      if (alu_a !== 32'h1007) begin
        errors++;
        $display("FAIL bp_head got=%h exp=%h", alu_a, 32'h1007);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, level} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL bp_full_pop_ready got=%b exp=%b", {in_ready, level}, {1'b0, 3'd4});
    end
    @(posedge clk); #1;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain got=busy exp=idle"); end
  endtask

  task automatic test_reserved;
    bit ok;
    push(32'hDEADBEEF, 32'h1, 2'd3);
    push(32'h1, 32'h1, 2'd0);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rsv_drain got=busy exp=idle"); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h10 + i, 32'h1, 2'd0);
    @(negedge clk);
    checks++;
    if ({level, out_valid} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre got=%b exp=%b", {level, out_valid}, {3'd3, 1'b1});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({level, out_valid, in_ready, out_result, out_err, alu_a} !== {3'd0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=%h", {level, out_valid, in_ready, out_result, out_err, alu_a},
               {3'd0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(32'd2, 32'd3, 2'd0);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_drain got=busy exp=idle"); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int c0, n0;
    out_ready = 1'b1;
    c0 = cyc;
    n0 = n_out;
    for (int i = 0; i < 20; i++) push($urandom, $urandom, 2'($urandom_range(0, 2)));
    checks++;
    if (cyc - c0 != 20) begin
      errors++;
      $display("FAIL b2b_push_rate got=%0d exp=20", cyc - c0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_out - n0 != 20) begin
      errors++;
      $display("FAIL b2b_out_count got=%0d exp=20", n_out - n0);
    end
    @(posedge clk); #1;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain got=busy exp=idle"); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_and_not();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
